// File: rtl/pipe_ctrl_hazard.sv
// E/M/W control pipeline registers with load-use stall, branch flush,
// EX-stage forwarding selects and saturating stall/flush event counters.
module pipe_ctrl_hazard #(
    parameter int CNT_W = 16,
    parameter int RA_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            PCBranchD,
    input  logic            SrcBSelD,
    input  logic            MemtoRegD,
    input  logic [1:0]      SrcASelD,
    input  logic [3:0]      ALUopD,
    input  logic [2:0]      immSelD,
    input  logic [2:0]      strCtrlD,
    input  logic [RA_W-1:0] rs1D,
    input  logic [RA_W-1:0] rs2D,
    input  logic [RA_W-1:0] rdD,
    input  logic            PCSrcE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            PCBranchE,
    output logic            SrcBSelE,
    output logic            MemtoRegE,
    output logic [1:0]      SrcASelE,
    output logic [3:0]      ALUopE,
    output logic [2:0]      immSelE,
    output logic [2:0]      strCtrlE,
    output logic [RA_W-1:0] rs1E,
    output logic [RA_W-1:0] rs2E,
    output logic [RA_W-1:0] rdE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            MemtoRegM,
    output logic [2:0]      strCtrlM,
    output logic [RA_W-1:0] rdM,
    output logic            RegWriteW,
    output logic            MemtoRegW,
    output logic [RA_W-1:0] rdW,
    output logic            StallF,
    output logic            StallD,
    output logic            FlushD,
    output logic            FlushE,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            pc_branch;
        logic            srcb_sel;
        logic            memtoreg;
        logic [1:0]      srca_sel;
        logic [3:0]      alu_op;
        logic [2:0]      imm_sel;
        logic [2:0]      str_ctrl;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
    } ex_t;

    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            memtoreg;
        logic [2:0]      str_ctrl;
        logic [RA_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic            reg_write;
        logic            memtoreg;
        logic [RA_W-1:0] rd;
    } wb_t;

    ex_t  ex_d, ex_q;
    mem_t mem_d, mem_q;
    wb_t  wb_d, wb_q;

    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;
    logic             lw_stall;

    // A taken branch squashes the stalled instruction, so it wins over the stall.
    assign lw_stall = ex_q.memtoreg && (ex_q.rd != '0) &&
                      ((ex_q.rd == rs1D) || (ex_q.rd == rs2D)) && !PCSrcE;

    assign StallF = lw_stall;
    assign StallD = lw_stall;
    assign FlushD = PCSrcE;
    assign FlushE = lw_stall || PCSrcE;

    always_comb begin
        ex_d = '0;
        if (!FlushE) begin
            ex_d.reg_write = RegWriteD;
            ex_d.mem_write = MemWriteD;
            ex_d.pc_branch = PCBranchD;
            ex_d.srcb_sel  = SrcBSelD;
            ex_d.memtoreg  = MemtoRegD;
            ex_d.srca_sel  = SrcASelD;
            ex_d.alu_op    = ALUopD;
            ex_d.imm_sel   = immSelD;
            ex_d.str_ctrl  = strCtrlD;
            ex_d.rs1       = rs1D;
            ex_d.rs2       = rs2D;
            ex_d.rd        = rdD;
        end
    end

    always_comb begin
        mem_d.reg_write = ex_q.reg_write;
        mem_d.mem_write = ex_q.mem_write;
        mem_d.memtoreg  = ex_q.memtoreg;
        mem_d.str_ctrl  = ex_q.str_ctrl;
        mem_d.rd        = ex_q.rd;
        wb_d.reg_write  = mem_q.reg_write;
        wb_d.memtoreg   = mem_q.memtoreg;
        wb_d.rd         = mem_q.rd;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (lw_stall && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (PCSrcE && (flush_cnt_q != '1))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    logic m_a, w_a, m_b, w_b;
    assign m_a = mem_q.reg_write && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs1);
    assign w_a = wb_q.reg_write  && (wb_q.rd  != '0) && (wb_q.rd  == ex_q.rs1);
    assign m_b = mem_q.reg_write && (mem_q.rd != '0) && (mem_q.rd == ex_q.rs2);
    assign w_b = wb_q.reg_write  && (wb_q.rd  != '0) && (wb_q.rd  == ex_q.rs2);

    assign ForwardAE = m_a ? 2'b10 : (w_a ? 2'b01 : 2'b00);
    assign ForwardBE = m_b ? 2'b10 : (w_b ? 2'b01 : 2'b00);

    assign RegWriteE = ex_q.reg_write;
    assign MemWriteE = ex_q.mem_write;
    assign PCBranchE = ex_q.pc_branch;
    assign SrcBSelE  = ex_q.srcb_sel;
    assign MemtoRegE = ex_q.memtoreg;
    assign SrcASelE  = ex_q.srca_sel;
    assign ALUopE    = ex_q.alu_op;
    assign immSelE   = ex_q.imm_sel;
    assign strCtrlE  = ex_q.str_ctrl;
    assign rs1E      = ex_q.rs1;
    assign rs2E      = ex_q.rs2;
    assign rdE       = ex_q.rd;
    assign RegWriteM = mem_q.reg_write;
    assign MemWriteM = mem_q.mem_write;
    assign MemtoRegM = mem_q.memtoreg;
    assign strCtrlM  = mem_q.str_ctrl;
    assign rdM       = mem_q.rd;
    assign RegWriteW = wb_q.reg_write;
    assign MemtoRegW = wb_q.memtoreg;
    assign rdW       = wb_q.rd;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl_hazard.md
Name: pipe_ctrl_hazard

Overview:
- Downstream consumer of the Decode-stage control bundle. Carries the bundle through the Execute, Memory and Writeback pipeline registers.
- Generates hazard control: load-use stall, branch/jump flush and EX-stage operand forwarding selects.
- Sits between the decoder outputs and the datapath stage registers of the 5-stage core.
- Includes saturating stall/flush event counters for performance debug.

Parameters:
CNT_W, 16, width of stall and flush event counters
RA_W, 5, register-address width

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-low reset
RegWriteD, MemWriteD, PCBranchD, SrcBSelD, MemtoRegD  in  1 each  decode control bits
SrcASelD  in  2  decode SrcA select
ALUopD  in  4  decode ALU op {funct7[5],funct3}
immSelD, strCtrlD  in  3 each  decode imm select / load-store width
rs1D, rs2D, rdD  in  RA_W each  decode register addresses
PCSrcE  in  1  branch/jump taken, resolved in Execute
RegWriteE, MemWriteE, PCBranchE, SrcBSelE, MemtoRegE  out  1 each  E-stage control
SrcASelE  out  2; ALUopE  out  4; immSelE, strCtrlE  out  3 each  E-stage control
rs1E, rs2E, rdE  out  RA_W each  E-stage addresses
RegWriteM, MemWriteM, MemtoRegM  out  1 each; strCtrlM  out  3; rdM  out  RA_W  M-stage
RegWriteW, MemtoRegW  out  1 each; rdW  out  RA_W  W-stage
StallF, StallD  out  1 each  hold PC / IF-ID register
FlushD, FlushE  out  1 each  bubble IF-ID / ID-EX register
ForwardAE, ForwardBE  out  2 each  00 regfile, 10 from M, 01 from W
stall_cnt, flush_cnt  out  CNT_W each  event counters

Behaviour:
- Reset (rst=0, async): all E/M/W registers and counters = 0. This yields bubbles: RegWrite=MemWrite=PCBranch=0, rd=0. Combinational outputs follow from the zeroed state.
- lwStall = MemtoRegE & (rdE!=0) & ((rdE==rs1D)|(rdE==rs2D)) & !PCSrcE.
- StallF = StallD = lwStall.
- FlushD = PCSrcE.
- FlushE = lwStall | PCSrcE.
- All hazard outputs are combinational, same cycle.
- ID/EX register, each rising edge:
  - FlushE=1: load all-zero bundle, including rs1E/rs2E/rdE.
  - Otherwise: capture the D bundle and rs1D/rs2D/rdD.
- EX/MEM register: always captures E values (RegWriteE, MemWriteE, MemtoRegE, strCtrlE, rdE).
- MEM/WB register: always captures M values. No stall on E/M/W (single-cycle memory).
- Latency: a D-stage bundle appears on the E outputs 1 cycle later, M after 2, W after 3.
- Forwarding, ForwardAE (ForwardBE identical using rs2E):
  - 10 if RegWriteM & rdM!=0 & rdM==rs1E;
  - else 01 if RegWriteW & rdW!=0 & rdW==rs1E;
  - else 00.
  - M has priority over W when both match.
- x0: rd=0 never causes forwarding or stall.
- Simultaneous load-use and taken branch: the branch wins. No stall; D and E both flushed (the stalled instruction is wrong-path).
- A load followed by a dependent load is stalled like any other use.
- stall_cnt increments on each cycle with lwStall=1; flush_cnt increments on each cycle with PCSrcE=1. Both saturate at 2^CNT_W-1 with no wrap.
- Reset asserted mid-operation: immediate clear to bubbles. The first cycle after release behaves as an empty pipeline.

Test Plan:
1. Reset: hold rst=0, drive RegWriteD=1, rdD=5 -> all E/M/W outputs 0, StallF=FlushE=0, counters 0. Release -> RegWriteE=1, rdE=5 next edge, RegWriteW=1 after 3 edges.
2. Forwarding: add x3 then add x4,x3,x3 -> in the consumer's E cycle ForwardAE=ForwardBE=10. With one independent instruction in between -> 01. With rd=x0 producer -> 00.
3. Load-use: lw x6 in E (MemtoRegE=1, rdE=6), rs1D=6 -> StallF=StallD=FlushE=1 for exactly 1 cycle. Next cycle E bundle all-zero. stall_cnt=1. Consumer then gets ForwardAE=01.
4. Taken branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1. Next E bundle zero with RegWriteE=MemWriteE=0. flush_cnt=1.
5. Conflict: load-use condition and PCSrcE=1 in the same cycle -> StallF=0, FlushD=FlushE=1. stall_cnt unchanged, flush_cnt +1.
6. Saturation: CNT_W=4, force 20 consecutive load-use stalls -> stall_cnt stays 15.
